// File: rtl/sc_pkg.sv
// Shared constants and the elaboration-time direction-vector generator
// for the stochastic-number sources.
package sc_pkg;

    localparam int BW_MIN     = 2;
    localparam int BW_MAX     = 10;
    localparam int DIM_VDC    = 0;
    localparam int DIM_SOBOL1 = 1;

    // Direction vector k for a given dimension, MSB-aligned in a bw-bit word.
    function automatic logic [BW_MAX-1:0] dirvec(input int dim, input int bw, input int k);
        logic [BW_MAX-1:0] v;
        v = BW_MAX'(1) << (bw - 1);
        if (dim == DIM_VDC) begin
            v = BW_MAX'(1) << (bw - 1 - k);
        end else begin
            // Primitive polynomial x+1: each vector folds in a half-shifted copy of the previous one.
            for (int j = 1; j < BW_MAX; j++) begin
                if (j <= k) v = v ^ (v >> 1);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/lsz.sv
// Least-significant-zero detector: returns the position of the lowest 0 bit
// of iGrey as an index and as a one-hot mask.
module lsz #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0]    iGrey,
    output logic [BITWIDTH-1:0]    oOneHot,
    output logic [LOGBITWIDTH-1:0] lszIdx
);

    assign oOneHot = ~iGrey & (iGrey + BITWIDTH'(1));

    // Scan from the top so the lowest zero wins; all-ones leaves the index at 0.
    always_comb begin
        lszIdx = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!iGrey[i]) lszIdx = LOGBITWIDTH'(i);
        end
    end

endmodule

// File: rtl/sobol_rng.sv
// Sobol sequence generator (Gray-code Antonov-Saleev form): a counter drives a
// least-significant-zero detector whose index selects the vector XORed into the output.
module sobol_rng
    import sc_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH),
    parameter int DIM         = DIM_VDC
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] oSobolNum,
    output logic [BITWIDTH-1:0] oIdx,
    output logic                oLast,
    output logic                oWrap
);

    localparam int NVEC = 2 ** LOGBITWIDTH;

    logic [BITWIDTH-1:0]    cnt;
    logic [BITWIDTH-1:0]    sobol;
    logic                   wrap;
    logic [LOGBITWIDTH-1:0] lsz_idx;
    logic [BITWIDTH-1:0]    vtab [NVEC];

    // Table padded to a power of two so every detector index selects a defined entry.
    for (genvar k = 0; k < NVEC; k++) begin : g_vtab
        if (k < BITWIDTH) begin : g_vec
            assign vtab[k] = BITWIDTH'(dirvec(DIM, BITWIDTH, k));
        end else begin : g_pad
            assign vtab[k] = '0;
        end
    end

    lsz #(
        .BITWIDTH    (BITWIDTH),
        .LOGBITWIDTH (LOGBITWIDTH)
    ) u_lsz (
        .iGrey   (cnt),
        .oOneHot (),
        .lszIdx  (lsz_idx)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt   <= '0;
            sobol <= '0;
            wrap  <= 1'b0;
        end else if (iClr) begin
            cnt   <= '0;
            sobol <= '0;
            wrap  <= 1'b0;
        end else if (iEn) begin
            if (&cnt) begin
                // End of period: the detector has no zero to report, so restart cleanly.
                cnt   <= '0;
                sobol <= '0;
                wrap  <= 1'b1;
            end else begin
                cnt   <= cnt + BITWIDTH'(1);
                sobol <= sobol ^ vtab[lsz_idx];
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign oSobolNum = sobol;
    assign oIdx      = cnt;
    assign oLast     = &cnt;
    assign oWrap     = wrap;

endmodule

// File: tb/tb_sobol_rng.sv
// Scoreboarded bench for sobol_rng: four instances (4-bit dim0/dim1, 8-bit, 2-bit)
// share stimulus and are checked against an arithmetic Gray-code Sobol model.
module tb_sobol_rng;

    logic clk;
    logic rst_n;
    logic en;
    logic clr;

    logic [3:0] s0, i0, s1, i1;
    logic [7:0] s2, i2;
    logic [1:0] s3, i3;
    logic       l0, w0, l1, w1, l2, w2, l3, w3;

    sobol_rng #(.BITWIDTH(4), .DIM(0)) u_bw4_d0 (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr),
        .oSobolNum(s0), .oIdx(i0), .oLast(l0), .oWrap(w0));
    sobol_rng #(.BITWIDTH(4), .DIM(1)) u_bw4_d1 (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr),
        .oSobolNum(s1), .oIdx(i1), .oLast(l1), .oWrap(w1));
    sobol_rng #(.BITWIDTH(8), .DIM(0)) u_bw8_d0 (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr),
        .oSobolNum(s2), .oIdx(i2), .oLast(l2), .oWrap(w2));
    sobol_rng #(.BITWIDTH(2), .DIM(0)) u_bw2_d0 (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr),
        .oSobolNum(s3), .oIdx(i3), .oLast(l3), .oWrap(w3));

    // Observation word per instance: {wrap, last, idx[9:0], sobol[9:0]}
    logic [21:0] obs [4];
    assign obs[0] = {w0, l0, 10'(i0), 10'(s0)};
    assign obs[1] = {w1, l1, 10'(i1), 10'(s1)};
    assign obs[2] = {w2, l2, 10'(i2), 10'(s2)};
    assign obs[3] = {w3, l3, 10'(i3), 10'(s3)};

    int bw_t  [4] = '{4, 4, 8, 2};
    int dim_t [4] = '{0, 1, 0, 0};
    int m_n   [4];

    logic [87:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    logic hist_en = 1'b0;
    int   h0 [$];
    int   h1 [$];
    int   h2 [$];
    int   h3 [$];
    int   hcnt = 0;
    int   wrap_cnt = 0;
    int   wrap_pos = 0;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int vdir(input int dim, input int bw, input int k);
        int v;
        if (dim == 0) return 1 << (bw - 1 - k);
        v = 1 << (bw - 1);
        for (int j = 1; j <= k; j++) v = v ^ (v >> 1);
        return v;
    endfunction

    // x_n is the XOR of the direction vectors selected by the bits of gray(n).
    function automatic int model_sn(input int dim, input int bw, input int n);
        int g;
        int x;
        g = n ^ (n >> 1);
        x = 0;
        for (int k = 0; k < bw; k++) begin
            if (((g >> k) & 1) == 1) x = x ^ vdir(dim, bw, k);
        end
        return x;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic c);
        logic [87:0] word;
        int          maxv;
        logic        wr;
        logic        lst;
        en  = e;
        clr = c;
        @(posedge clk);
        #1;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            maxv = (1 << bw_t[i]) - 1;
            wr   = 1'b0;
            if (c) begin
                m_n[i] = 0;
            end else if (e) begin
                if (m_n[i] == maxv) begin
                    m_n[i] = 0;
                    wr     = 1'b1;
                end else begin
                    m_n[i] = m_n[i] + 1;
                end
            end
            lst = (m_n[i] == maxv);
            word[i*22 +: 22] = {wr, lst, 10'(m_n[i]), 10'(model_sn(dim_t[i], bw_t[i], m_n[i]))};
        end
        exp_q.push_back(word);
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (obs[i] !== 22'd0) begin
                fails++;
                $display("FAIL %s inst%0d got %h exp 000000", name, i, obs[i]);
            end
        end
    endtask

    task automatic check_eq(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", name, got, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [87:0] mon_e;
    logic [7:0]  mon_g;
    logic [7:0]  mon_r;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs[i] !== mon_e[i*22 +: 22]) begin
                    fails++;
                    $display("FAIL sb inst%0d got %h exp %h", i, obs[i], mon_e[i*22 +: 22]);
                end
            end
            mon_g = i2 ^ (i2 >> 1);
            for (int b = 0; b < 8; b++) mon_r[b] = mon_g[7-b];
            tests++;
            if (mon_r !== s2) begin
                fails++;
                $display("FAIL bitrev_gray idx %0d got %0d exp %0d", i2, s2, mon_r);
            end
            if (hist_en) begin
                h0.push_back(int'(s0));
                h1.push_back(int'(s1));
                h2.push_back(int'(s2));
                h3.push_back(int'(s3));
                hcnt++;
                if (w2) begin
                    wrap_cnt++;
                    wrap_pos = hcnt;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int exp_d0 [16] = '{8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0};
    int exp_d1 [8]  = '{8, 4, 12, 6, 14, 2, 10, 5};
    int exp_b2 [4]  = '{2, 3, 1, 0};
    int exp_tg [4]  = '{8, 8, 12, 12};
    int seen   [256];

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < 4; i++) m_n[i] = 0;
        #3;
        check_zero("reset_init");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Full 16-step period with iEn held high
        hist_en = 1'b1;
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0);
        hist_en = 1'b0;
        for (int k = 0; k < 16; k++) check_eq("seq_dim0", h0[k], exp_d0[k]);
        for (int k = 0; k < 8; k++)  check_eq("seq_dim1", h1[k], exp_d1[k]);
        for (int k = 0; k < 16; k++) check_eq("seq_bw2", h3[k], exp_b2[k % 4]);
        for (int v = 0; v < 16; v++) seen[v] = 0;
        for (int k = 0; k < 16; k++) seen[h1[k]]++;
        for (int v = 0; v < 16; v++) check_eq("perm_dim1", seen[v], 1);

        // Hold
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

        // Stall toggling
        h0.delete(); h1.delete(); h2.delete(); h3.delete();
        hist_en = 1'b1;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        hist_en = 1'b0;
        for (int k = 0; k < 4; k++) check_eq("toggle_dim0", h0[k], exp_tg[k]);

        // Clear together with enable at n=6
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        check_eq("pre_clr_idx", int'(i0), 6);
        step(1'b1, 1'b1);
        check_eq("clr_sobol", int'(s0), 0);
        check_eq("clr_idx", int'(i0), 0);
        check_eq("clr_wrap", int'(w0), 0);

        // Asynchronous reset mid-sequence, between clock edges
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        for (int i = 0; i < 4; i++) m_n[i] = 0;
        #1;
        rst_n = 1'b1;

        // 8-bit full period
        h0.delete(); h1.delete(); h2.delete(); h3.delete();
        hcnt = 0;
        wrap_cnt = 0;
        wrap_pos = 0;
        hist_en = 1'b1;
        for (int k = 0; k < 256; k++) step(1'b1, 1'b0);
        hist_en = 1'b0;
        for (int v = 0; v < 256; v++) seen[v] = 0;
        for (int k = 0; k < 256; k++) seen[h2[k]]++;
        for (int v = 0; v < 256; v++) check_eq("perm_bw8", seen[v], 1);
        check_eq("wrap_cnt_bw8", wrap_cnt, 1);
        check_eq("wrap_pos_bw8", wrap_pos, 256);

        // Randomized enable / clear traffic
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        #20;
        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
